// File: rtl/apb_master_bridge.sv
// APB requester bridge: accepts one command on a valid/ready stream, runs a
// single APB transfer (SETUP then ACCESS with wait states and a PREADY
// timeout guard), and returns the result on a valid/ready response stream.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  // APB requester
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter compare value; only meaningful when the guard is enabled.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  state_t     state;
  logic [7:0] timeout_cnt;
  logic       timeout_hit;

  // Abort condition for the current ACCESS cycle (PREADY is checked first).
  assign timeout_hit = TIMEOUT_EN && (timeout_cnt == TIMEOUT_LAST);

  // Handshake/status views of the state register.
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign busy      = (state == SETUP) || (state == ACCESS);

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      timeout_cnt <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values and the later completion assignment wins cleanly.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            PADDR       <= cmd_addr;
            PWRITE      <= cmd_write;
            PWDATA      <= cmd_wdata;
            PSEL        <= 1'b1;
            timeout_cnt <= '0;
            state       <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else if (timeout_cnt != 8'hFF) begin
            // Saturate rather than wrap when the guard is disabled.
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end

        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
